// File: rtl/traffic_phase_ctrl_if.sv
// Detector inputs and lamp outputs of the traffic phase controller.
// The controller side uses the slave modport; the detector/lamp side uses master.
interface traffic_phase_ctrl_if #(
   parameter int NUM_PHASES = 4
);
   localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

   logic                  TICK_EN;
   logic [NUM_PHASES-1:0] REQ;
   logic                  PED_REQ;
   logic [NUM_PHASES-1:0] GREEN;
   logic [NUM_PHASES-1:0] YELLOW;
   logic [NUM_PHASES-1:0] RED;
   logic [PH_W-1:0]       PHASE;
   logic                  PED_WALK;
   logic                  CYCLE_DONE;

   modport master (
      output TICK_EN, REQ, PED_REQ,
      input  GREEN, YELLOW, RED, PHASE, PED_WALK, CYCLE_DONE
   );

   modport slave (
      input  TICK_EN, REQ, PED_REQ,
      output GREEN, YELLOW, RED, PHASE, PED_WALK, CYCLE_DONE
   );
endinterface

// File: rtl/traffic_phase_ctrl.sv
// Demand-actuated signal phase controller: ALLRED/GREEN/YELLOW/WALK sequencing
// over NUM_PHASES conflicting phases, timed by a prescaled tick, registered lamps.
module traffic_phase_ctrl #(
   parameter int NUM_PHASES = 4,
   parameter int CNT_W      = 8,
   parameter int GREEN_MIN  = 4,
   parameter int GREEN_MAX  = 8,
   parameter int YELLOW_T   = 2,
   parameter int ALLRED_T   = 1,
   parameter int PED_T      = 3
) (
   input logic                 CLOCK,
   input logic                 RESET,
   input logic                 VSS,
   input logic                 VDD,
   traffic_phase_ctrl_if.slave bus
);
   localparam int PH_W  = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
   localparam int GEL_W = CNT_W + 1;

   function automatic bit dur_ok(input int d);
      return (d >= 1) && (longint'(d) <= (longint'(1) << CNT_W));
   endfunction

   if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_phases
      $error("NUM_PHASES must lie in 2..8");
   end
   if (!dur_ok(GREEN_MIN) || !dur_ok(GREEN_MAX) || !dur_ok(YELLOW_T) ||
       !dur_ok(ALLRED_T) || !dur_ok(PED_T) || GREEN_MAX < GREEN_MIN) begin : g_bad_dur
      $error("interval parameters out of range");
   end

   localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(ALLRED_T - 1);
   localparam logic [CNT_W-1:0] LD_WALK   = CNT_W'(PED_T - 1);
   localparam logic [GEL_W-1:0] GMIN      = GEL_W'(GREEN_MIN);
   localparam logic [GEL_W-1:0] GMAX      = GEL_W'(GREEN_MAX);

   typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_t;

   // Supply pins carry no logic.
   logic unused_supply;
   assign unused_supply = VSS ^ VDD;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      tmr_q, tmr_d;
   logic [GEL_W-1:0]      gel_q, gel_d;
   logic [PH_W-1:0]       phase_q, phase_d;
   logic [NUM_PHASES-1:0] pend_q, pend_d;
   logic                  ppend_q, ppend_d;
   logic [NUM_PHASES-1:0] green_q, green_d, yellow_q, yellow_d, red_q, red_d;
   logic                  walk_q, walk_d, cdone_q, cdone_d;

   logic                  expired, other_pend, found, enter_green, enter_walk;
   logic [GEL_W-1:0]      gel_inc;
   logic [PH_W-1:0]       nxt_ph;
   logic [PH_W:0]         cand;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      gel_d   = gel_q;
      phase_d = phase_q;

      expired    = (tmr_q == '0);
      gel_inc    = (gel_q == GMAX) ? gel_q : gel_q + 1'b1;
      other_pend = |(pend_q & ~(NUM_PHASES'(1) << phase_q));

      // Round-robin search starting after the current phase, current phase last.
      nxt_ph = phase_q;
      found  = 1'b0;
      cand   = '0;
      for (int k = 1; k <= NUM_PHASES; k++) begin
         cand = {1'b0, phase_q} + (PH_W+1)'(k);
         if (cand >= (PH_W+1)'(NUM_PHASES)) cand = cand - (PH_W+1)'(NUM_PHASES);
         if (!found && pend_q[cand[PH_W-1:0]]) begin
            found  = 1'b1;
            nxt_ph = cand[PH_W-1:0];
         end
      end

      if (bus.TICK_EN) begin
         case (state_q)
            S_ALLRED: begin
               if (!expired) tmr_d = tmr_q - 1'b1;
               else if (ppend_q) begin
                  state_d = S_WALK;
                  tmr_d   = LD_WALK;
               end else begin
                  state_d = S_GREEN;
                  tmr_d   = LD_GREEN;
                  gel_d   = '0;
                  phase_d = nxt_ph;
               end
            end
            S_GREEN: begin
               gel_d = gel_inc;
               if (!expired) tmr_d = tmr_q - 1'b1;
               else if (gel_inc >= GMIN && !(bus.REQ[phase_q] && gel_inc < GMAX) &&
                        (other_pend || ppend_q)) begin
                  state_d = S_YELLOW;
                  tmr_d   = LD_YELLOW;
               end
            end
            S_YELLOW, S_WALK: begin
               if (!expired) tmr_d = tmr_q - 1'b1;
               else begin
                  state_d = S_ALLRED;
                  tmr_d   = LD_ALLRED;
               end
            end
            default: begin
               state_d = S_ALLRED;
               tmr_d   = LD_ALLRED;
            end
         endcase
      end

      // A clear on entry overrides a request captured in the same cycle.
      enter_green = (state_q != S_GREEN) && (state_d == S_GREEN);
      enter_walk  = (state_q != S_WALK) && (state_d == S_WALK);
      pend_d  = (pend_q | bus.REQ) & ~(enter_green ? (NUM_PHASES'(1) << phase_d) : '0);
      ppend_d = (ppend_q | bus.PED_REQ) & ~enter_walk;

      green_d  = (state_d == S_GREEN)  ? (NUM_PHASES'(1) << phase_d) : '0;
      yellow_d = (state_d == S_YELLOW) ? (NUM_PHASES'(1) << phase_d) : '0;
      red_d    = ~(green_d | yellow_d);
      walk_d   = (state_d == S_WALK);
      cdone_d  = enter_green && (phase_q == PH_W'(NUM_PHASES - 1)) && (phase_d == '0);
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q  <= S_ALLRED;
         tmr_q    <= LD_ALLRED;
         gel_q    <= '0;
         phase_q  <= '0;
         pend_q   <= '0;
         ppend_q  <= 1'b0;
         green_q  <= '0;
         yellow_q <= '0;
         red_q    <= '1;
         walk_q   <= 1'b0;
         cdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         gel_q    <= gel_d;
         phase_q  <= phase_d;
         pend_q   <= pend_d;
         ppend_q  <= ppend_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         red_q    <= red_d;
         walk_q   <= walk_d;
         cdone_q  <= cdone_d;
      end
   end

   assign bus.GREEN      = green_q;
   assign bus.YELLOW     = yellow_q;
   assign bus.RED        = red_q;
   assign bus.PHASE      = phase_q;
   assign bus.PED_WALK   = walk_q;
   assign bus.CYCLE_DONE = cdone_q;
endmodule

// File: doc/traffic_phase_ctrl.md
# traffic_phase_ctrl

Parametrised, demand-actuated traffic-signal phase controller: the generalised successor to the fixed two-road benchmark controller. It handles NUM_PHASES conflicting phases with programmable minimum/maximum green, yellow, all-red and pedestrian-walk intervals. It is driven by a prescaled tick and sits between detector-input conditioning and the lamp-driver outputs. All outputs are registered.

## Interface
Parameters:
- NUM_PHASES, 4: number of mutually exclusive phases; allowed range 2–8.
- CNT_W, 8: timer width.
- GREEN_MIN, 4: minimum green, in ticks.
- GREEN_MAX, 8: maximum green under extension, in ticks; must satisfy GREEN_MAX ≥ GREEN_MIN.
- YELLOW_T, 2: yellow interval, in ticks.
- ALLRED_T, 1: all-red clearance, in ticks.
- PED_T, 3: pedestrian walk interval, in ticks.
- Every duration must lie in 1..2^CNT_W. Elaboration fails otherwise.

Ports:
- CLOCK, in, 1: single clock; all state changes on the rising edge.
- RESET, in, 1: synchronous, active-high.
- VSS, VDD, in, 1 each: supply pins, kept for library compatibility; no logical function.
- TICK_EN, in, 1: timer advance strobe.
- REQ, in, NUM_PHASES: vehicle detector per phase, level.
- PED_REQ, in, 1: pedestrian push-button, level.
- GREEN, out, NUM_PHASES: one-hot or zero.
- YELLOW, out, NUM_PHASES: one-hot or zero.
- RED, out, NUM_PHASES: the complement of (GREEN | YELLOW).
- PHASE, out, clog2(NUM_PHASES): current phase index.
- PED_WALK, out, 1: walk lamp.
- CYCLE_DONE, out, 1: one-cycle pulse when PHASE wraps from NUM_PHASES-1 to 0.

## Operation
- States: ALLRED, GREEN, YELLOW, WALK. A single down-counter TMR (CNT_W bits) times each state, plus a green-elapsed counter GEL.
- The interval for a state with duration D is loaded as D-1 on state entry. TMR decrements on TICK_EN. The state's interval expires when TMR==0 and TICK_EN is high.
- Pending latches PEND[i] and PPEND:
  - REQ[i] sets PEND[i]; PED_REQ sets PPEND.
  - PEND[i] clears on entry to GREEN with PHASE=i.
  - PPEND clears on entry to WALK.
  - If set and clear fall in the same cycle, clear wins.
- ALLRED expiry, evaluated in order:
  1. If PPEND is set, go to WALK.
  2. Otherwise, the next phase is the first i with PEND[i] set, searching PHASE+1, PHASE+2, … with wrap, and PHASE itself last. If no PEND bit is set, PHASE is unchanged.
  3. Go to GREEN.
- WALK expiry: go to ALLRED with a fresh ALLRED_T load. The phase is not advanced.
- GREEN: GEL counts ticks since entry. A tick at which the interval has expired is counted as ended-green once GEL ≥ GREEN_MIN. At that point, evaluated in order:
  1. If REQ[PHASE] is high and GEL < GREEN_MAX, stay in GREEN (extension). TMR holds at 0.
  2. Else, if no PEND bit of another phase is set and PPEND is clear, stay in GREEN (rest-in-green). There is no maximum on rest-in-green; it exits on the first tick after any such request latches.
  3. Else, go to YELLOW.
- YELLOW expiry: go to ALLRED.
- Outputs per state:
  - GREEN and YELLOW assert only bit PHASE, in their respective states.
  - PED_WALK is high only in WALK. All RED bits are high in ALLRED and WALK.
- With TICK_EN low, the FSM, TMR and GEL freeze. Request latches still capture.

## Timing
- Reset values:
  - State: ALLRED, with TMR=ALLRED_T-1 and PHASE=0.
  - GREEN=0, YELLOW=0, RED all ones.
  - PED_WALK=0, CYCLE_DONE=0.
  - PEND=0, PPEND=0, GEL=0.
- RESET asserted mid-interval forces these values on the next edge and discards pending requests.
- Outputs change on the edge after the expiring tick.
- With TICK_EN held high, a state of duration D is visible for exactly D cycles.
- A request sampled high at edge k is visible in PEND at k+1 and is eligible at any expiry evaluated at k+1 or later.
- CYCLE_DONE pulses in the same cycle as the PHASE update, i.e. the first GREEN cycle of phase 0 after a wrap.

## Test plan
- Reset: hold RESET for 3 cycles with REQ=1111 -> all outputs at reset values. In the first cycle after release: RED=1111, PHASE=0.
- Full rotation: TICK_EN=1, REQ pulsed 1111 for one cycle after reset -> sequence is ALLRED 1, GREEN ph1 4, YELLOW 2, ALLRED 1, then ph2, ph3, ph0 each with the same 4/2/1 timing. CYCLE_DONE pulses once, on ph0 green entry.
- Skip and rest: only REQ[2] pulsed -> ph2 green after 1 ALLRED cycle; it rests in green indefinitely with no PHASE change. A later REQ[0] pulse -> yellow starts at the next tick.
- Extension: REQ[1] held high during ph1 green while REQ[3] is pending -> green lasts 8 cycles, then yellow.
- Pedestrian: PED_REQ pulsed during ph0 green with REQ[1] pending -> YELLOW 2, ALLRED 1, WALK 3 (PED_WALK=1, RED=1111), ALLRED 1, then ph1 green.
- Freeze and reset mid-operation: TICK_EN low for 10 cycles in YELLOW -> no state change. RESET asserted in WALK -> ALLRED, PHASE=0, PPEND=0 on the next edge.
